mccu_fsm: RTL and testbench



---
 rtl/mccu_pkg.sv | 87 ++++++++
 rtl/mccu_decode.sv | 48 ++++
 rtl/mccu_fsm.sv | 146 ++++++++++++++
 tb/tb_mccu_fsm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mccu_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, datapath
// select values, opcode/function constants and the decoded-instruction flags.
package mccu_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'b000,
    ST_ID  = 3'b001,
    ST_EXE = 3'b010,
    ST_MEM = 3'b011,
    ST_WB  = 3'b100
  } state_t;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_TGT  = 2'b01;
  localparam logic [1:0] PC_REGA = 2'b10;
  localparam logic [1:0] PC_JUMP = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef struct packed {
    logic i_add;
    logic i_sub;
    logic i_and;
    logic i_or;
    logic i_xor;
    logic i_sll;
    logic i_srl;
    logic i_sra;
    logic i_jr;
    logic i_addi;
    logic i_andi;
    logic i_ori;
    logic i_xori;
    logic i_lw;
    logic i_sw;
    logic i_beq;
    logic i_bne;
    logic i_lui;
    logic i_j;
    logic i_jal;
  } instr_t;

  function automatic logic is_shift(instr_t d);
    return d.i_sll | d.i_srl | d.i_sra;
  endfunction

  function automatic logic is_itype_alu(instr_t d);
    return d.i_addi | d.i_andi | d.i_ori | d.i_xori | d.i_lui;
  endfunction

endpackage

// File: rtl/mccu_decode.sv
// Combinational op/func decode into one-hot instruction flags; anything that
// matches no supported instruction is reported as illegal.
module mccu_decode
  import mccu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output instr_t     dec,
  output logic       rtype,
  output logic       ill
);

  always_comb begin
    dec = '0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  dec.i_add = 1'b1;
          FN_SUB:  dec.i_sub = 1'b1;
          FN_AND:  dec.i_and = 1'b1;
          FN_OR:   dec.i_or  = 1'b1;
          FN_XOR:  dec.i_xor = 1'b1;
          FN_SLL:  dec.i_sll = 1'b1;
          FN_SRL:  dec.i_srl = 1'b1;
          FN_SRA:  dec.i_sra = 1'b1;
          FN_JR:   dec.i_jr  = 1'b1;
          default: ;
        endcase
      end
      OP_J:    dec.i_j    = 1'b1;
      OP_JAL:  dec.i_jal  = 1'b1;
      OP_BEQ:  dec.i_beq  = 1'b1;
      OP_BNE:  dec.i_bne  = 1'b1;
      OP_ADDI: dec.i_addi = 1'b1;
      OP_ANDI: dec.i_andi = 1'b1;
      OP_ORI:  dec.i_ori  = 1'b1;
      OP_XORI: dec.i_xori = 1'b1;
      OP_LUI:  dec.i_lui  = 1'b1;
      OP_LW:   dec.i_lw   = 1'b1;
      OP_SW:   dec.i_sw   = 1'b1;
      default: ;
    endcase
  end

  assign rtype = (op == OP_RTYPE);
  assign ill   = ~(|dec);

endmodule

// File: rtl/mccu_fsm.sv
// Multicycle control unit: a single state register sequences IF/ID/EXE/MEM/WB;
// every datapath control is decoded combinationally from state and the IR.
module mccu_fsm
  import mccu_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_rdy,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       sext,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluc,
  output logic [1:0] pcsrc,
  output logic       ill,
  output logic [2:0] state
);

  state_t state_q;
  state_t state_next;
  instr_t dec;
  logic   rtype;
  logic   dec_ill;
  logic   is_jump;
  logic   is_branch;
  logic   wpc_raw, wir_raw, wmem_raw, wreg_raw, ill_raw, jal_raw;

  mccu_decode u_decode (
    .op    (op),
    .func  (func),
    .dec   (dec),
    .rtype (rtype),
    .ill   (dec_ill)
  );

  assign is_jump   = dec.i_j | dec.i_jal | dec.i_jr;
  assign is_branch = dec.i_beq | dec.i_bne;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= ST_IF;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = ST_IF;
    wpc_raw    = 1'b0;
    wir_raw    = 1'b0;
    wmem_raw   = 1'b0;
    wreg_raw   = 1'b0;
    ill_raw    = 1'b0;
    jal_raw    = 1'b0;
    iord       = 1'b0;
    regrt      = 1'b0;
    m2reg      = 1'b0;
    shift      = 1'b0;
    sext       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    aluc       = ALUC_ADD;
    pcsrc      = PC_ALU;
    case (state_q)
      ST_IF: begin
        alusrcb    = SRCB_FOUR;
        wir_raw    = mem_rdy;
        wpc_raw    = mem_rdy;
        state_next = mem_rdy ? ST_ID : ST_IF;
      end
      ST_ID: begin
        // The ALU computes PC+4 + (imm<<2) here so a branch target is ready for EXE.
        alusrcb = SRCB_BR;
        if (dec.i_j | dec.i_jal) begin
          wpc_raw = 1'b1;
          pcsrc   = PC_JUMP;
        end
        if (dec.i_jal) begin
          wreg_raw = 1'b1;
          jal_raw  = 1'b1;
        end
        if (dec.i_jr) begin
          wpc_raw = 1'b1;
          pcsrc   = PC_REGA;
        end
        ill_raw    = dec_ill;
        state_next = (is_jump | dec_ill) ? ST_IF : ST_EXE;
      end
      ST_EXE: begin
        alusrca = 1'b1;
        shift   = is_shift(dec);
        alusrcb = (rtype | is_branch) ? SRCB_REG : SRCB_IMM;
        sext    = dec.i_addi | dec.i_lw | dec.i_sw | is_branch;
        if (dec.i_add | dec.i_addi | dec.i_lw | dec.i_sw) aluc = ALUC_ADD;
        else if (dec.i_sub | is_branch)                   aluc = ALUC_SUB;
        else if (dec.i_and | dec.i_andi)                  aluc = ALUC_AND;
        else if (dec.i_or | dec.i_ori)                    aluc = ALUC_OR;
        else if (dec.i_xor | dec.i_xori)                  aluc = ALUC_XOR;
        else if (dec.i_lui)                               aluc = ALUC_LUI;
        else if (dec.i_sll)                               aluc = ALUC_SLL;
        else if (dec.i_srl)                               aluc = ALUC_SRL;
        else if (dec.i_sra)                               aluc = ALUC_SRA;
        if ((dec.i_beq & z) | (dec.i_bne & ~z)) begin
          wpc_raw = 1'b1;
          pcsrc   = PC_TGT;
        end
        if (is_branch)                state_next = ST_IF;
        else if (dec.i_lw | dec.i_sw) state_next = ST_MEM;
        else                          state_next = ST_WB;
      end
      ST_MEM: begin
        iord = 1'b1;
        if (dec.i_sw) begin
          wmem_raw   = 1'b1;
          state_next = mem_rdy ? ST_IF : ST_MEM;
        end else if (dec.i_lw) begin
          state_next = mem_rdy ? ST_WB : ST_MEM;
        end
      end
      ST_WB: begin
        wreg_raw = 1'b1;
        regrt    = is_itype_alu(dec) | dec.i_lw;
        m2reg    = dec.i_lw;
      end
      default: state_next = ST_IF;
    endcase
  end

  // Reset must kill every write enable at once, including a held sw write.
  assign wpc   = wpc_raw  & clrn;
  assign wir   = wir_raw  & clrn;
  assign wmem  = wmem_raw & clrn;
  assign wreg  = wreg_raw & clrn;
  assign ill   = ill_raw  & clrn;
  assign jal   = jal_raw  & clrn;
  assign state = state_q;

endmodule

// File: tb/tb_mccu_fsm.sv
// Randomized self-checking bench for mccu_fsm: each instruction is expanded by a
// behavioural model into its expected per-cycle output trace and compared every cycle.
module tb_mccu_fsm;

  logic       clk = 1'b0;
  logic       clrn, z, mem_rdy;
  logic [5:0] op, func;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca, ill;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] aluc;
  logic [2:0] state;

  mccu_fsm dut (
    .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .shift(shift), .sext(sext), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluc(aluc), .pcsrc(pcsrc), .ill(ill), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic wpc, wir, wmem, wreg, ill, jal, iord, regrt, m2reg, shift, sext, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsrc;
  } outs_t;

  typedef struct {
    logic       clrn;
    logic [5:0] op, func;
    logic       rdy, z;
    outs_t      exp;
  } cyc_t;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_XOR = 4, K_SLL = 5,
                 K_SRL = 6, K_SRA = 7, K_JR = 8, K_ADDI = 9, K_ANDI = 10, K_ORI = 11,
                 K_XORI = 12, K_LW = 13, K_SW = 14, K_BEQ = 15, K_BNE = 16, K_LUI = 17,
                 K_J = 18, K_JAL = 19, K_ILL_OP = 20, K_ILL_FN = 21, K_ILL_OP2 = 22;

  cyc_t  seq[$];
  outs_t exp_now;
  outs_t act;
  logic  exp_valid = 1'b0;
  int    cyc_no = 0;
  int    checks = 0;
  int    errors = 0;

  assign act = {state, wpc, wir, wmem, wreg, ill, jal, iord, regrt, m2reg, shift, sext,
                alusrca, alusrcb, aluc, pcsrc};

  function automatic logic [11:0] enc(int k);
    case (k)
      K_ADD:   return {6'b000000, 6'b100000};
      K_SUB:   return {6'b000000, 6'b100010};
      K_AND:   return {6'b000000, 6'b100100};
      K_OR:    return {6'b000000, 6'b100101};
      K_XOR:   return {6'b000000, 6'b100110};
      K_SLL:   return {6'b000000, 6'b000000};
      K_SRL:   return {6'b000000, 6'b000010};
      K_SRA:   return {6'b000000, 6'b000011};
      K_JR:    return {6'b000000, 6'b001000};
      K_ADDI:  return {6'b001000, 6'b010101};
      K_ANDI:  return {6'b001100, 6'b100000};
      K_ORI:   return {6'b001101, 6'b000011};
      K_XORI:  return {6'b001110, 6'b111111};
      K_LW:    return {6'b100011, 6'b001000};
      K_SW:    return {6'b101011, 6'b100010};
      K_BEQ:   return {6'b000100, 6'b000000};
      K_BNE:   return {6'b000101, 6'b100000};
      K_LUI:   return {6'b001111, 6'b000010};
      K_J:     return {6'b000010, 6'b100100};
      K_JAL:   return {6'b000011, 6'b000001};
      K_ILL_OP: return {6'b111111, 6'b100000};
      K_ILL_FN: return {6'b000000, 6'b001001};
      default: return {6'b010000, 6'b000000};
    endcase
  endfunction

  function automatic logic [3:0] exe_aluc(int k);
    case (k)
      K_SUB, K_BEQ, K_BNE:  return 4'b0100;
      K_AND, K_ANDI:        return 4'b0001;
      K_OR, K_ORI:          return 4'b0101;
      K_XOR, K_XORI:        return 4'b0010;
      K_LUI:                return 4'b0110;
      K_SLL:                return 4'b0011;
      K_SRL:                return 4'b0111;
      K_SRA:                return 4'b1111;
      default:              return 4'b0000;
    endcase
  endfunction

  function automatic outs_t idle_out(logic r);
    outs_t e = '0;
    e.alusrcb = 2'b01;
    e.wpc = r;
    e.wir = r;
    return e;
  endfunction

  task automatic push(input logic c, input logic r, input logic zz, input bit ir_ok,
                      input int k, input outs_t e);
    cyc_t x;
    logic [11:0] w;
    w = ir_ok ? enc(k) : 12'($urandom);
    x.clrn = c; x.op = w[11:6]; x.func = w[5:0]; x.rdy = r; x.z = zz; x.exp = e;
    seq.push_back(x);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'($urandom), 1'($urandom), 1'b0, 0, idle_out(1'b0));
  endtask

  // Expand one instruction into the cycle-by-cycle trace the control unit must produce.
  task automatic build(input int k, input int ifst, input int mst, input logic zz);
    outs_t e;
    bit    jump, illegal, branch, taken;
    jump    = (k == K_J) || (k == K_JAL) || (k == K_JR);
    illegal = (k >= K_ILL_OP);
    branch  = (k == K_BEQ) || (k == K_BNE);
    for (int i = 0; i < ifst; i++) push(1'b1, 1'b0, 1'($urandom), 1'b0, k, idle_out(1'b0));
    push(1'b1, 1'b1, 1'($urandom), 1'b0, k, idle_out(1'b1));
    e = '0; e.state = 3'd1; e.alusrcb = 2'b11;
    if (k == K_J || k == K_JAL) begin e.wpc = 1'b1; e.pcsrc = 2'b11; end
    if (k == K_JAL) begin e.wreg = 1'b1; e.jal = 1'b1; end
    if (k == K_JR) begin e.wpc = 1'b1; e.pcsrc = 2'b10; end
    e.ill = illegal;
    push(1'b1, 1'($urandom), 1'($urandom), 1'b1, k, e);
    if (jump || illegal) return;
    e = '0; e.state = 3'd2; e.alusrca = 1'b1;
    e.shift   = (k == K_SLL) || (k == K_SRL) || (k == K_SRA);
    e.alusrcb = (k <= K_SRA || branch) ? 2'b00 : 2'b10;
    e.aluc    = exe_aluc(k);
    e.sext    = (k == K_ADDI) || (k == K_LW) || (k == K_SW) || branch;
    taken     = (k == K_BEQ && zz) || (k == K_BNE && !zz);
    if (taken) begin e.wpc = 1'b1; e.pcsrc = 2'b01; end
    push(1'b1, 1'($urandom), zz, 1'b1, k, e);
    if (branch) return;
    if (k == K_LW || k == K_SW) begin
      e = '0; e.state = 3'd3; e.iord = 1'b1; e.wmem = (k == K_SW);
      for (int i = 0; i < mst; i++) push(1'b1, 1'b0, 1'($urandom), 1'b1, k, e);
      push(1'b1, 1'b1, 1'($urandom), 1'b1, k, e);
    end
    if (k != K_SW) begin
      e = '0; e.state = 3'd4; e.wreg = 1'b1;
      e.regrt = (k >= K_ADDI && k <= K_LW) || (k == K_LUI);
      e.m2reg = (k == K_LW);
      push(1'b1, 1'($urandom), 1'($urandom), 1'b1, k, e);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic apply_stimulus();
    foreach (seq[i]) begin
      @(posedge clk);
      #1;
      clrn    = seq[i].clrn;
      op      = seq[i].op;
      func    = seq[i].func;
      mem_rdy = seq[i].rdy;
      z       = seq[i].z;
      exp_now = seq[i].exp;
      exp_valid = 1'b1;
      cyc_no++;
    end
  endtask

  task automatic check_output();
    checks++;
    if (act !== exp_now) begin
      errors++;
      $display("[TB] FAIL outputs cycle %0d op=%b func=%b got %b want %b",
               cyc_no, op, func, act, exp_now);
    end
  endtask

  always @(negedge clk) if (exp_valid) check_output();

  task automatic run(input string name, input int k, input int ifst, input int mst,
                     input logic zz, input int want_len);
    seq.delete();
    build(k, ifst, mst, zz);
    if (want_len > 0) check_val({name, "_len"}, seq.size(), want_len);
    apply_stimulus();
  endtask

  initial begin
    int k, ifst, mst, cut;
    clrn = 1'b1; op = '0; func = '0; z = 1'b0; mem_rdy = 1'b0;
    #2 clrn = 1'b0;
    seq.delete();
    add_reset(3);
    apply_stimulus();

    run("add",     K_ADD,    0, 0, 1'b0, 4);
    run("lw",      K_LW,     0, 2, 1'b1, 7);
    run("beq_t",   K_BEQ,    0, 0, 1'b1, 3);
    run("beq_n",   K_BEQ,    0, 0, 1'b0, 3);
    run("bne_t",   K_BNE,    0, 0, 1'b0, 3);
    run("bne_n",   K_BNE,    0, 0, 1'b1, 3);
    run("jal",     K_JAL,    0, 0, 1'b0, 2);
    run("ill",     K_ILL_OP, 0, 0, 1'b0, 2);
    run("sw",      K_SW,     0, 0, 1'b0, 4);
    run("sra_st",  K_SRA,    2, 0, 1'b1, 6);

    // sw stalled in MEM, then reset lands while wmem is held.
    seq.delete();
    build(K_SW, 0, 3, 1'b0);
    check_val("sw_stall_len", seq.size(), 7);
    while (seq.size() > 4) void'(seq.pop_back());
    add_reset(2);
    apply_stimulus();
    #1;
    check_val("sw_abort_state", int'(state), 0);
    check_val("sw_abort_wmem", int'(wmem), 0);

    for (int n = 0; n < 160; n++) begin
      k    = $urandom_range(0, 22);
      ifst = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      mst  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      seq.delete();
      build(k, ifst, mst, 1'($urandom));
      if ($urandom_range(0, 11) == 0) begin
        cut = $urandom_range(1, seq.size());
        while (seq.size() > cut) void'(seq.pop_back());
        add_reset($urandom_range(1, 2));
      end
      apply_stimulus();
    end

    @(posedge clk);
    #1 exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
